// File: rtl/ula_sequenciador_pkg.sv
// ula_sequenciador_pkg
//   Shared definitions for the ULA sequencer: opcodes, FSM encodings,
//   the packed command record and a legality helper.
package ula_sequenciador_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_MAX = 3'd4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    // Opcodes above OP_MAX leave the ULA output undefined and are never issued.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= OP_MAX);
    endfunction

endpackage

// File: rtl/ula_sequenciador_if.sv
// ula_sequenciador_if
//   Command and result handshake bundle of the ULA sequencer.
//   master: control/test logic side (offers commands, consumes results)
//   slave : sequencer side (accepts commands, returns results)
//   cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_op : command channel
//   res_valid/res_ready/res_data/res_err   : result channel
interface ula_sequenciador_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [2:0] cmd_op;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_err;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, res_ready,
        input  cmd_ready, res_valid, res_data, res_err
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, res_ready,
        output cmd_ready, res_valid, res_data, res_err
    );
endinterface

// File: rtl/ula_sequenciador_fifo_cmd.sv
// ula_sequenciador_fifo_cmd
//   Synchronous command FIFO, head visible on dout without a pop cycle.
//   clk, rst_n : clock, synchronous active-low reset
//   push, din  : write request and data
//   pop, dout  : read request and current head
//   full, empty: status from registered pointers
module ula_sequenciador_fifo_cmd #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit separates full from empty when the indices match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the slot being written, so push is allowed when full.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ula_sequenciador.sv
// ula_sequenciador
//   Drives the 8-bit ULA one command at a time from a small FIFO, waits out
//   the ULA register latency and returns the result with an error flag.
//   clk, rst_n          : clock, synchronous active-low reset
//   bus (slave)         : command and result handshakes
//   alu_a, alu_b, alu_op: registered operands/opcode to the ULA
//   alu_s               : ULA result
//   busy                : command in flight or queued
//
//   state  | meaning
//   S_IDLE | waiting for a queued command; pops the head when present
//   S_WAIT | operands held on the ULA, wait counter running down
//   S_DONE | result presented until res_valid && res_ready
module ula_sequenciador
    import ula_sequenciador_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ula_sequenciador_if.slave    bus,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    output logic [2:0]           alu_op,
    input  logic [7:0]           alu_s,
    output logic                 busy
);
    localparam int CNT_W = $clog2(ALU_LAT + 2);
    // ALU_LAT+1 edges are counted after the operands are driven; the result is
    // captured on the edge after that, one edge beyond the worst-case need.
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(ALU_LAT + 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] wait_cnt;
    logic [7:0]       res_data_q;
    logic             res_err_q;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic [CMD_W-1:0] fifo_dout;
    cmd_t             head;

    assign bus.cmd_ready = !fifo_full;
    assign fifo_push     = bus.cmd_valid && !fifo_full;
    assign fifo_pop      = (state == S_IDLE) && !fifo_empty;
    assign head          = cmd_t'(fifo_dout);

    ula_sequenciador_fifo_cmd #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo_cmd (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   ({bus.cmd_a, bus.cmd_b, bus.cmd_op}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        if (op_is_legal(head.op)) begin
                            alu_a    <= head.a;
                            alu_b    <= head.b;
                            alu_op   <= head.op;
                            wait_cnt <= WAIT_LOAD;
                            state    <= S_WAIT;
                        end else begin
                            // ULA is left untouched; its output is undefined for these codes.
                            res_data_q <= '0;
                            res_err_q  <= 1'b1;
                            state      <= S_DONE;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        res_data_q <= alu_s;
                        res_err_q  <= 1'b0;
                        state      <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.res_valid = (state == S_DONE);
    assign bus.res_data  = res_data_q;
    assign bus.res_err   = res_err_q;
    assign busy          = (state != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_ula_sequenciador.sv
module tb_ula_sequenciador;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_s;
    logic       busy;

    always #5 clk = ~clk;

    ula_sequenciador_if bus ();

    ula_sequenciador #(
        .DEPTH   (4),
        .ALU_LAT (2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .alu_a  (alu_a),
        .alu_b  (alu_b),
        .alu_op (alu_op),
        .alu_s  (alu_s),
        .busy   (busy)
    );

    // ULA environment model: input register then output register.
    function automatic logic [7:0] ula_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return 8'h5A;
        endcase
    endfunction

    logic [7:0] ula_a_r, ula_b_r, ula_s_r;
    logic [2:0] ula_op_r;
    always @(posedge clk) begin
        ula_a_r  <= alu_a;
        ula_b_r  <= alu_b;
        ula_op_r <= alu_op;
        ula_s_r  <= ula_fn(ula_a_r, ula_b_r, ula_op_r);
    end
    assign alu_s = ula_s_r;

    // Reference model: {err, data} from the arithmetic rules.
    function automatic logic [8:0] ref_res(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        int s;
        case (op)
            3'd0:    s = (int'(a) + int'(b)) % 256;
            3'd1:    s = (int'(a) - int'(b) + 256) % 256;
            3'd2:    s = int'(a & b);
            3'd3:    s = int'(a | b);
            3'd4:    s = int'(a ^ b);
            default: return {1'b1, 8'h00};
        endcase
        return {1'b0, 8'(s)};
    endfunction

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_op    = op;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 200 && !bus.cmd_ready; i++) tick();
        check("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
        if (!bus.cmd_ready) begin
            bus.cmd_valid = 1'b0;
            return;
        end
        tick();
        bus.cmd_valid = 1'b0;
        exp_q.push_back(ref_res(a, b, op));
    endtask

    task automatic collect_one(output logic [8:0] got);
        bus.res_ready = 1'b1;
        for (int i = 0; i < 200 && !bus.res_valid; i++) tick();
        check("res_valid_wait", 32'(bus.res_valid), 32'd1);
        got = {bus.res_err, bus.res_data};
        tick();
        bus.res_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] exp_data;
        logic       exp_err;
        int         exp_lat;
        logic [7:0] exp_alu_a;
        logic [7:0] exp_alu_b;
        logic [2:0] exp_alu_op;
    } vec_t;

    // One command on an idle sequencer: latency, held operands, result, release.
    task automatic run_vec(input vec_t v);
        int lat;
        push_cmd(v.a, v.b, v.op);
        bus.res_ready = 1'b1;
        lat = 0;
        while (lat < 50 && !bus.res_valid) begin
            tick();
            lat++;
            check("alu_a_held", 32'(alu_a), 32'(v.exp_alu_a));
            check("alu_b_held", 32'(alu_b), 32'(v.exp_alu_b));
            check("alu_op_held", 32'(alu_op), 32'(v.exp_alu_op));
        end
        check("latency", 32'(lat), 32'(v.exp_lat));
        check("res_data", 32'(bus.res_data), 32'(v.exp_data));
        check("res_err", 32'(bus.res_err), 32'(v.exp_err));
        tick();
        check("res_valid_drop", 32'(bus.res_valid), 32'd0);
        bus.res_ready = 1'b0;
        exp_q.delete();
    endtask

    // Result must stay put while presented and not accepted.
    logic       hold_prev = 1'b0;
    logic [8:0] held_val  = '0;
    always @(negedge clk) begin
        if (rst_n && hold_prev) begin
            check("res_held_valid", 32'(bus.res_valid), 32'd1);
            check("res_held_data", 32'({bus.res_err, bus.res_data}), 32'(held_val));
        end
        hold_prev = rst_n && bus.res_valid && !bus.res_ready;
        held_val  = {bus.res_err, bus.res_data};
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[10];
    logic [8:0] got;
    logic [2:0] bp_ops[6];

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_op    = '0;
        bus.res_ready = 1'b0;
        rst_n         = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_data", 32'(bus.res_data), 32'd0);
        check("rst_res_err", 32'(bus.res_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Table vectors: functions, wrap, error keeps previous operands.
        vecs[0] = '{8'h7F, 8'h01, 3'd0, 8'h80, 1'b0, 5, 8'h7F, 8'h01, 3'd0};
        vecs[1] = '{8'd200, 8'd100, 3'd0, 8'd44, 1'b0, 5, 8'd200, 8'd100, 3'd0};
        vecs[2] = '{8'd5, 8'd10, 3'd1, 8'hFB, 1'b0, 5, 8'd5, 8'd10, 3'd1};
        vecs[3] = '{8'hF0, 8'h3C, 3'd2, 8'h30, 1'b0, 5, 8'hF0, 8'h3C, 3'd2};
        vecs[4] = '{8'hF0, 8'h3C, 3'd3, 8'hFC, 1'b0, 5, 8'hF0, 8'h3C, 3'd3};
        vecs[5] = '{8'hF0, 8'h3C, 3'd4, 8'hCC, 1'b0, 5, 8'hF0, 8'h3C, 3'd4};
        vecs[6] = '{8'h01, 8'h02, 3'd6, 8'h00, 1'b1, 1, 8'hF0, 8'h3C, 3'd4};
        vecs[7] = '{8'hFF, 8'h01, 3'd0, 8'h00, 1'b0, 5, 8'hFF, 8'h01, 3'd0};
        vecs[8] = '{8'h00, 8'h01, 3'd1, 8'hFF, 1'b0, 5, 8'h00, 8'h01, 3'd1};
        vecs[9] = '{8'h0A, 8'h0B, 3'd7, 8'h00, 1'b1, 1, 8'h00, 8'h01, 3'd1};
        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Backpressure: one in flight plus four queued fills the FIFO.
        bp_ops = '{3'd0, 3'd1, 3'd5, 3'd3, 3'd4, 3'd2};
        exp_q.delete();
        bus.res_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_cmd(8'(16 * i + 3), 8'(i + 7), bp_ops[i]);
        tick();
        check("bp_cmd_ready_low", 32'(bus.cmd_ready), 32'd0);
        check("bp_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 20 && !bus.res_valid; i++) tick();
        check("bp_first_valid", 32'(bus.res_valid), 32'd1);
        for (int i = 0; i < 4; i++) tick();
        check("bp_first_data", 32'({bus.res_err, bus.res_data}), 32'(exp_q[0]));
        check("bp_still_full", 32'(bus.cmd_ready), 32'd0);
        fork
            push_cmd(8'h99, 8'h11, bp_ops[5]);
            begin
                for (int j = 0; j < 6; j++) begin
                    collect_one(got);
                    check("bp_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) check("bp_order", 32'(got), 32'(exp_q.pop_front()));
                end
            end
        join
        check("bp_drained", 32'(busy), 32'd0);

        // Reset during WAIT with three queued.
        exp_q.delete();
        for (int i = 0; i < 4; i++) push_cmd(8'(i + 40), 8'(i + 2), 3'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst2_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst2_busy", 32'(busy), 32'd0);
        check("rst2_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst2_alu_a", 32'(alu_a), 32'd0);
        exp_q.delete();
        run_vec('{8'h03, 8'h04, 3'd1, 8'hFF, 1'b0, 5, 8'h03, 8'h04, 3'd1});
        for (int i = 0; i < 4; i++) tick();
        check("rst2_idle", 32'(busy), 32'd0);

        // Randomized traffic with random result backpressure.
        exp_q.delete();
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    int gap;
                    gap = $urandom_range(0, 3);
                    for (int g = 0; g < gap; g++) tick();
                    push_cmd(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
                end
            end
            begin
                int rx;
                int cyc;
                rx  = 0;
                cyc = 0;
                while (rx < 40 && cyc < 4000) begin
                    bus.res_ready = 1'($urandom_range(0, 1));
                    if (bus.res_valid && bus.res_ready) begin
                        check("rnd_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
                        if (exp_q.size() != 0)
                            check("rnd_result", 32'({bus.res_err, bus.res_data}), 32'(exp_q.pop_front()));
                        rx++;
                    end
                    tick();
                    cyc++;
                end
                bus.res_ready = 1'b0;
                check("rnd_count", 32'(rx), 32'd40);
            end
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
